shift_unit_seq: RTL and testbench
=================================

Name: shift_unit_seq

Overview:
- Parametrised, multi-cycle successor to the combinational shift-right-logical unit used by the ALU shift path.
- Supports SLL/SRL/SRA/ROR on a WIDTH-bit operand.
- Shift amount comes either from the instruction shamt field or from the low bits of a register (variable shifts).
- Shifts STEP bits per clock under a start/busy/done handshake, so the shifter area stays small and the ALU stalls on busy.

Parameters:
- WIDTH, 32, operand/result width. Power of two, >=16.
- STEP, 4, maximum bits shifted per cycle. 1 <= STEP <= WIDTH.
- SHW, log2(WIDTH), shift-amount width (derived; 5 for WIDTH=32).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- var  input  1  0: shamt = B[6+SHW-1:6] (instruction field); 1: shamt = B[SHW-1:0] (register).
- A  input  WIDTH  value to shift.
- B  input  WIDTH  shift-amount source.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: res updated.
- res  output  WIDTH  result. Holds until the next done.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, busy=0, done=0, res=0, internal work/remaining/op regs=0. Applies mid-operation as well; the in-flight result is discarded and res is not updated.
- States: IDLE, SHIFT.
- IDLE, start=1 at an edge:
  - Latch work=A, op, remaining=shamt per var.
  - Go to SHIFT; busy=1 from the next cycle.
  - A, B, op and var may change afterwards without effect.
- IDLE, start=0: stay; done=0.
- SHIFT, remaining != 0, at each edge:
  - n = min(STEP, remaining); remaining -= n.
  - work updated by n positions:
    - SLL: zero fill from the LSB.
    - SRL: zero fill from the MSB.
    - SRA: fill with the latched work MSB (sign preserved across steps).
    - ROR: bits leaving the LSB enter the MSB.
- SHIFT, remaining == 0, at an edge: res<=work, done<=1 (this cycle only), busy<=0, go to IDLE.
- Latency: with k = ceil(shamt/STEP), done is high in the cycle (k+1) edges after the start edge. shamt=0 gives 1.
- busy and done are never high together. done deasserts after exactly one cycle.
- start while busy=1: ignored, not queued.
- start in the same cycle done is high (state IDLE): accepted. Back-to-back ops are allowed with no bubble beyond that.
- Upper bits of B outside the selected field are ignored. shamt ranges 0..WIDTH-1 (no shift-by-WIDTH case).
- Arithmetic is unsigned on remaining. No overflow or flag outputs.

Test Plan:
- SRL, var=0, A=0x80000000, B[10:6]=31, STEP=4 -> k=8; done high 9 edges after start; res=0x00000001; busy high for the 8 preceding cycles.
- SRA, var=1, A=0x80000000, B=0x00000004 -> res=0xF8000000, done 2 edges after start. Repeat with A=0x70000000 -> res=0x07000000.
- ROR, var=1, A=0x12345678, B=8 -> res=0x78123456, latency 3. SLL, var=0, A=0x0000000F, B[10:6]=28 -> res=0xF0000000, latency 8.
- shamt=0, op=SRL, A=0xDEADBEEF -> done 1 edge after start, res=0xDEADBEEF, busy never high. Follow with start in the done cycle (SLL by 1) -> accepted; res=0xBD5B7DDE two edges later.
- Protocol: start with shamt=20, then pulse start again with different A two cycles later -> second request ignored; result matches the first only. Change A/B during SHIFT -> no effect.
- Reset: rst high for one edge midway through a 31-bit shift -> next cycle busy=0, done=0, res=0. No done pulse follows. A new start then completes normally.

Source files
------------

// File: rtl/shift_unit_seq.sv
// Multi-cycle barrel-free shifter: SLL/SRL/SRA/ROR on a WIDTH-bit operand,
// advancing at most STEP bit positions per clock under a start/busy/done handshake.
module shift_unit_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             var_amt,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    // One extra bit so STEP == WIDTH is representable.
    localparam logic [SHW:0] STEP_W = (SHW + 1)'(STEP);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] work_reg;
    logic [SHW-1:0]   remaining_reg;
    logic [1:0]       op_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] res_reg;

    logic [SHW-1:0]   shamt;
    logic [SHW:0]     step_n;
    logic [SHW-1:0]   remaining_next;
    logic [WIDTH-1:0] work_next;
    logic [WIDTH-1:0] step_res [STEP+1];

    assign shamt = var_amt ? B[SHW-1:0] : B[6+SHW-1:6];

    always_comb begin
        step_n = ({1'b0, remaining_reg} > STEP_W) ? STEP_W : {1'b0, remaining_reg};
        remaining_next = remaining_reg - step_n[SHW-1:0];
    end

    // Every candidate shift distance 0..STEP is a fixed rewire; the step amount
    // only drives a narrow mux, which is what keeps this cheaper than a barrel.
    generate
        for (genvar gi = 0; gi <= STEP; gi++) begin : g_step
            localparam int ROT = (WIDTH - gi) % WIDTH;
            assign step_res[gi] =
                (op_reg == OP_SLL) ? (work_reg << gi) :
                (op_reg == OP_SRL) ? (work_reg >> gi) :
                (op_reg == OP_SRA) ? WIDTH'($signed(work_reg) >>> gi) :
                                     ((work_reg >> gi) | (work_reg << ROT));
        end
    endgenerate

    assign work_next = step_res[step_n];

    // busy tracks outstanding shift work; the final write-back cycle shows
    // busy=0 so a zero-amount shift never raises busy at all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            work_reg      <= '0;
            remaining_reg <= '0;
            op_reg        <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            res_reg       <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        work_reg      <= A;
                        op_reg        <= op;
                        remaining_reg <= shamt;
                        busy_reg      <= (shamt != '0);
                        state_reg     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (remaining_reg != '0) begin
                        work_reg      <= work_next;
                        remaining_reg <= remaining_next;
                        busy_reg      <= (remaining_next != '0);
                    end else begin
                        res_reg   <= work_reg;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign res  = res_reg;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: hand-computed results, latencies,
// busy profile, handshake corner cases and mid-operation reset.
module tb_shift_unit_seq;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic             var_amt;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;

    int n_checks = 0;
    int n_pass   = 0;

    shift_unit_seq #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .var_amt (var_amt),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .res     (res)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issues one request at the next falling edge, then waits for done.
    task automatic run_op(input string tag, input logic [1:0] o, input logic v,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        int edges = 0;
        int busy_cnt = 0;
        int overlap = 0;
        @(negedge clk);
        op = o; var_amt = v; A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_cnt += int'(busy);
        overlap += int'(busy & done);
        while (edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
            overlap += int'(busy & done);
            if (done) break;
            busy_cnt += int'(busy);
        end
        check({tag, "_timeout"}, 64'(done), 64'(1));
        check({tag, "_lat"}, 64'(edges), 64'(exp_lat));
        check({tag, "_res"}, 64'(res), 64'(exp_res));
        check({tag, "_busycyc"}, 64'(busy_cnt), 64'(exp_lat - 1));
        check({tag, "_overlap"}, 64'(overlap), 64'(0));
        $display("op %s: op=%0d var=%0d A=0x%08h B=0x%08h res=0x%08h lat=%0d",
                 tag, o, v, a, b, res, edges);
    endtask

    initial begin
        int edges;
        int dones;
        rst = 1'b1; start = 1'b0; op = 2'b00; var_amt = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_res", 64'(res), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // SRL by instruction field 31 (low bits of B are decoys)
        run_op("srl31", 2'b01, 1'b0, 32'h8000_0000, 32'hABCD_07E5, 32'h0000_0001, 9);
        run_op("sra4n", 2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFE4, 32'hF800_0000, 2);
        run_op("sra4p", 2'b10, 1'b1, 32'h7000_0000, 32'h0000_0004, 32'h0700_0000, 2);
        run_op("ror8",  2'b11, 1'b1, 32'h1234_5678, 32'h0000_0008, 32'h7812_3456, 3);
        run_op("sll28", 2'b00, 1'b0, 32'h0000_000F, 32'h0000_0700, 32'hF000_0000, 8);
        run_op("ror13", 2'b11, 1'b1, 32'h0000_0001, 32'h0000_000D, 32'h0008_0000, 5);
        run_op("srl0",  2'b01, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1);
        // issued in the done cycle of the previous op
        run_op("sll1",  2'b00, 1'b1, 32'hDEAD_BEEF, 32'h0000_0001, 32'hBD5B_7DDE, 2);

        // second start while busy is ignored; input changes mid-shift have no effect
        @(negedge clk);
        op = 2'b01; var_amt = 1'b1; A = 32'hFFFF_0000; B = 32'd20; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        op = 2'b00; A = 32'h1234_5678; B = 32'd3; var_amt = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; A = 32'h5555_5555; B = 32'hFFFF_FFFF;
        edges = 3;
        while (!done && edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("ign_lat", 64'(edges), 64'(6));
        check("ign_res", 64'(res), 64'h0000_0FFF);
        dones = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            dones += int'(done);
        end
        check("ign_nodone", 64'(dones), 64'(0));
        $display("op ignore: res=0x%08h lat=%0d extra_dones=%0d", res, edges, dones);

        // reset midway through a 31-bit shift
        @(negedge clk);
        op = 2'b01; var_amt = 1'b1; A = 32'h8000_0000; B = 32'd31; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_res", 64'(res), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            dones += int'(done);
        end
        check("mid_rst_nodone", 64'(dones), 64'(0));
        $display("op midreset: busy=%0d done=%0d res=0x%08h extra_dones=%0d", busy, done, res, dones);
        run_op("sra5", 2'b10, 1'b0, 32'h8000_0000, 32'h0000_0140, 32'hFC00_0000, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
